spi_slave_controller: RTL and testbench

SPI slave-side transfer engine, the counterpart of the master controller on the same SPI link. Oversamples external SCK/SS_n on the system clock, shifts MOSI in and MISO out, and raises SPIF when a full byte has been received. Sits between the SPI pins and the SPDR/SPSR register file, and is active only when SPE=1 and MSTR=0.

---
 rtl/spi_slave_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_slave_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_controller.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_controller
//  Purpose  : SPI slave transfer engine. Oversamples SCK/SS_n/MOSI on clk,
//             shifts MOSI in and MISO out in all four CPOL/CPHA modes, and
//             raises a sticky SPIF when a full word has been received.
//  Options  : SPI_SLAVE_DORD_EN adds a DORD input selecting LSB-first order.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave_controller #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              SPE,
  input  logic              MSTR,
  input  logic              CPOL,
  input  logic              CPHA,
`ifdef SPI_SLAVE_DORD_EN
  input  logic              DORD,
`endif
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  input  logic              spif_clr,
  output logic              MISO,
  output logic              MISO_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              SPIF,
  output logic              WCOL,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_prev;

  logic [DATA_W-1:0] tx_buf;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] rx_shift;
  logic [CNT_W-1:0]  bit_cnt;
  logic              armed;      // CPHA=1: first leading edge already seen
  logic              lsb_first;

  logic sck_s;
  logic mosi_s;
  logic en;
  logic ss_act;
  logic sck_rise;
  logic sck_fall;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic tx_bit;
  logic present;

  // Synchronise the asynchronous pin inputs into the clk domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync  <= {SYNC_STAGES{CPOL}};
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= CPOL;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s   = sck_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign en      = SPE & ~MSTR;
  assign ss_act  = ~ss_sync[SYNC_STAGES-1] & en;

  // Leading edge leaves the idle level set by CPOL; CPHA picks which edge samples
  assign sck_rise    = sck_s & ~sck_prev;
  assign sck_fall    = ~sck_s & sck_prev;
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

`ifdef SPI_SLAVE_DORD_EN
  // Bit order is frozen for the whole transfer at the start of a select
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsb_first <= 1'b0;
    end else if (state == IDLE && ss_act) begin
      lsb_first <= DORD;
    end
  end
`else
  assign lsb_first = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: losing select always wins over a completing word
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ss_act) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!ss_act) begin
          state_nxt = IDLE;
        end else if (sample_edge && bit_cnt == LAST_BIT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = ss_act ? ACTIVE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift datapath: TX shifter, RX assembler, bit counter and CPHA=1 arming
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      armed     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bit_cnt <= '0;
          armed   <= 1'b0;
          if (ss_act) shift_reg <= tx_buf;
        end
        ACTIVE: begin
          if (!ss_act) begin
            bit_cnt <= '0;
            armed   <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_shift <= lsb_first ? {mosi_s, rx_shift[DATA_W-1:1]}
                                    : {rx_shift[DATA_W-2:0], mosi_s};
              bit_cnt  <= bit_cnt + 1'b1;
            end
            if (shift_edge) begin
              if (CPHA && !armed) begin
                armed <= 1'b1;
              end else begin
                shift_reg <= lsb_first ? {1'b0, shift_reg[DATA_W-1:1]}
                                       : {shift_reg[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
        DONE: begin
          shift_reg <= tx_buf;
          bit_cnt   <= '0;
          armed     <= 1'b0;
        end
        default: begin
          bit_cnt <= '0;
          armed   <= 1'b0;
        end
      endcase
    end
  end

  // Host-side registers: TX buffer, received word and sticky status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_buf  <= '0;
      rx_data <= '0;
      SPIF    <= 1'b0;
      WCOL    <= 1'b0;
    end else begin
      if (tx_load && !busy) tx_buf <= tx_data;
      if (state == DONE) rx_data <= rx_shift;
      if (state == DONE) begin
        SPIF <= 1'b1;
      end else if (spif_clr) begin
        SPIF <= 1'b0;
      end
      if (tx_load && busy) begin
        WCOL <= 1'b1;
      end else if (spif_clr) begin
        WCOL <= 1'b0;
      end
    end
  end

  // In CPHA=1 the first bit is only presented once the first leading edge arrives
  assign present = ~CPHA | armed;
  assign tx_bit  = lsb_first ? shift_reg[0] : shift_reg[DATA_W-1];
  assign MISO_oe = ss_act;
  assign MISO    = ss_act & present & tx_bit;
  assign busy    = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_controller
//  Purpose  : Self-checking bench for spi_slave_controller. A bit-level SPI
//             master drives the pins; a word-level model of the register
//             file (TX buffer, RX word, SPIF, WCOL) predicts results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_controller;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk      = 1'b0;
  logic              rst      = 1'b0;
  logic              SCK      = 1'b0;
  logic              SS_n     = 1'b1;
  logic              MOSI     = 1'b0;
  logic              SPE      = 1'b0;
  logic              MSTR     = 1'b0;
  logic              CPOL     = 1'b0;
  logic              CPHA     = 1'b0;
  logic [DATA_W-1:0] tx_data  = '0;
  logic              tx_load  = 1'b0;
  logic              spif_clr = 1'b0;
  logic              MISO;
  logic              MISO_oe;
  logic [DATA_W-1:0] rx_data;
  logic              SPIF;
  logic              WCOL;
  logic              busy;
`ifdef SPI_SLAVE_DORD_EN
  logic              DORD     = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Word-level model of the slave's host-visible state
  logic [7:0] m_tx_buf = 8'h00;
  logic [7:0] m_rx     = 8'h00;
  logic       m_spif   = 1'b0;
  logic       m_wcol   = 1'b0;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_rx;
    logic [7:0] exp_master;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  spi_slave_controller #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SCK      (SCK),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .SPE      (SPE),
    .MSTR     (MSTR),
    .CPOL     (CPOL),
    .CPHA     (CPHA),
`ifdef SPI_SLAVE_DORD_EN
    .DORD     (DORD),
`endif
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .spif_clr (spif_clr),
    .MISO     (MISO),
    .MISO_oe  (MISO_oe),
    .rx_data  (rx_data),
    .SPIF     (SPIF),
    .WCOL     (WCOL),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Half an SCK period is four clk periods
  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic half_load(input bit do_load, input logic [7:0] val);
    if (do_load) begin
      tx_data = val;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      half();
    end
  endtask

  // Half period after the final sample edge; optionally checks SPIF timing
  // and pulses spif_clr during the completion cycle
  task automatic final_half(input bit chk_lat, input bit clr_at_done);
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    if (chk_lat) check("spif_latency_pre", SPIF, 1'b0);
    @(negedge clk);
    if (clr_at_done) spif_clr = 1'b1;
    @(posedge clk);
    #1;
    if (chk_lat) check("spif_latency_post", SPIF, 1'b1);
    @(negedge clk);
    spif_clr = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    @(negedge clk);
    CPOL = pol;
    CPHA = pha;
    SCK  = pol;
    half();
  endtask

  task automatic do_load(input logic [7:0] val);
    @(negedge clk);
    tx_data = val;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    m_tx_buf = val;
  endtask

  task automatic do_clear();
    @(negedge clk);
    spif_clr = 1'b1;
    @(negedge clk);
    spif_clr = 1'b0;
    m_spif = 1'b0;
    m_wcol = 1'b0;
  endtask

  task automatic ss_begin();
    @(negedge clk);
    SCK  = CPOL;
    SS_n = 1'b0;
    half();
  endtask

  task automatic ss_end();
    half();
    SS_n = 1'b1;
    half();
  endtask

  // Bit-level SPI master: sends mbyte MSB-first, collects MISO MSB-first
  task automatic xfer_byte(input logic [7:0] mbyte, input int nbits, input int load_at,
                           input logic [7:0] load_val, input bit chk_lat, input bit clr_at_done,
                           output logic [7:0] sbyte, output logic pre_first);
    logic [7:0] r;
    r = 8'h00;
    pre_first = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (CPHA == 1'b0) begin
        MOSI = mbyte[7-i];
        half_load(load_at == i, load_val);
        if (i == 0) pre_first = MISO;
        r = {r[6:0], MISO};
        SCK = ~SCK;
        if (i == 7) final_half(chk_lat, clr_at_done);
        else half();
        SCK = ~SCK;
      end else begin
        if (i == 0) pre_first = MISO;
        SCK = ~SCK;
        MOSI = mbyte[7-i];
        half_load(load_at == i, load_val);
        r = {r[6:0], MISO};
        SCK = ~SCK;
        if (i == 7) final_half(chk_lat, clr_at_done);
        else half();
      end
    end
    sbyte = r;
  endtask

  task automatic model_check(input string pfx);
    check({pfx, "_rx_data"}, rx_data, m_rx);
    check({pfx, "_spif"}, SPIF, m_spif);
    check({pfx, "_wcol"}, WCOL, m_wcol);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_miso_oe"}, MISO_oe, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sb;
    logic [7:0] sb2;
    logic       pf;

    vecs[0] = '{cpol: 1'b0, cpha: 1'b0, tx: 8'h3C, mosi: 8'hA5, exp_rx: 8'hA5, exp_master: 8'h3C};
    vecs[1] = '{cpol: 1'b1, cpha: 1'b1, tx: 8'hF0, mosi: 8'h81, exp_rx: 8'h81, exp_master: 8'hF0};
    vecs[2] = '{cpol: 1'b0, cpha: 1'b1, tx: 8'hC3, mosi: 8'h5A, exp_rx: 8'h5A, exp_master: 8'hC3};
    vecs[3] = '{cpol: 1'b1, cpha: 1'b0, tx: 8'h96, mosi: 8'h0F, exp_rx: 8'h0F, exp_master: 8'h96};

    // Reset state
    SPE = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_miso", MISO, 1'b0);
    check("reset_miso_oe", MISO_oe, 1'b0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_spif", SPIF, 1'b0);
    check("reset_wcol", WCOL, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b1;
    half();

    // Master mode keeps the slave idle even when selected
    MSTR = 1'b1;
    SS_n = 1'b0;
    half();
    check("mstr_busy", busy, 1'b0);
    check("mstr_miso_oe", MISO_oe, 1'b0);
    check("mstr_miso", MISO, 1'b0);
    SS_n = 1'b1;
    MSTR = 1'b0;
    half();

    // Table-driven single-word transfers in each mode
    for (int v = 0; v < 4; v++) begin
      set_mode(vecs[v].cpol, vecs[v].cpha);
      do_load(vecs[v].tx);
      do_clear();
      ss_begin();
      check("vec_busy_active", busy, 1'b1);
      check("vec_miso_oe", MISO_oe, 1'b1);
      xfer_byte(vecs[v].mosi, 8, -1, 8'h00, 1'b1, 1'b0, sb, pf);
      check("vec_pre_first", pf, vecs[v].cpha ? 1'b0 : vecs[v].exp_master[7]);
      check("vec_master_rx", sb, vecs[v].exp_master);
      ss_end();
      m_rx = vecs[v].exp_rx;
      m_spif = 1'b1;
      model_check("vec");
    end

    // Abort after four bits, then a clean transfer
    set_mode(1'b0, 1'b0);
    do_clear();
    ss_begin();
    xfer_byte(8'hFF, 4, -1, 8'h00, 1'b0, 1'b0, sb, pf);
    ss_end();
    model_check("abort");
    ss_begin();
    xfer_byte(8'h5A, 8, -1, 8'h00, 1'b1, 1'b0, sb, pf);
    ss_end();
    check("after_abort_master", sb, m_tx_buf);
    m_rx = 8'h5A;
    m_spif = 1'b1;
    model_check("after_abort");

    // Write collision mid-transfer; old buffer is resent next time
    do_load(8'h22);
    ss_begin();
    xfer_byte(8'hC7, 8, 3, 8'h11, 1'b0, 1'b0, sb, pf);
    ss_end();
    check("wcol_inflight_master", sb, 8'h22);
    m_wcol = 1'b1;
    m_rx = 8'hC7;
    m_spif = 1'b1;
    model_check("wcol");
    ss_begin();
    xfer_byte(8'h3E, 8, -1, 8'h00, 1'b0, 1'b0, sb, pf);
    ss_end();
    check("wcol_resend_master", sb, 8'h22);
    m_rx = 8'h3E;
    model_check("wcol_resend");
    do_clear();
    model_check("wcol_cleared");

    // Back-to-back words with spif_clr colliding with the second completion
    set_mode(1'b0, 1'b1);
    do_load(8'h6B);
    do_clear();
    ss_begin();
    xfer_byte(8'h12, 8, -1, 8'h00, 1'b1, 1'b0, sb, pf);
    check("b2b_rx1", rx_data, 8'h12);
    xfer_byte(8'h34, 8, -1, 8'h00, 1'b0, 1'b1, sb2, pf);
    check("b2b_spif_set_wins", SPIF, 1'b1);
    check("b2b_rx2", rx_data, 8'h34);
    check("b2b_master1", sb, 8'h6B);
    check("b2b_master2", sb2, 8'h6B);
    ss_end();
    m_rx = 8'h34;
    m_spif = 1'b1;
    model_check("b2b");

`ifdef SPI_SLAVE_DORD_EN
    // LSB-first order
    set_mode(1'b0, 1'b0);
    DORD = 1'b1;
    do_load(8'h01);
    do_clear();
    ss_begin();
    xfer_byte(8'h80, 8, -1, 8'h00, 1'b0, 1'b0, sb, pf);
    ss_end();
    DORD = 1'b0;
    check("dord_master", sb, 8'h80);
    m_rx = 8'h01;
    m_spif = 1'b1;
    model_check("dord");
`endif

    // Randomised transfers against the word-level model
    for (int it = 0; it < 16; it++) begin
      logic [7:0] mb;
      logic [7:0] ld;
      logic [7:0] exp_tx;
      int nb;
      int la;
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
      mb = 8'($urandom);
      ld = 8'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
      la = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      exp_tx = m_tx_buf;
      ss_begin();
      xfer_byte(mb, nb, la, ld, 1'b0, 1'b0, sb, pf);
      ss_end();
      if (la >= 0) m_wcol = 1'b1;
      if (nb == 8) begin
        m_rx = mb;
        m_spif = 1'b1;
        check("rand_master", sb, exp_tx);
      end
      model_check("rand");
      if ($urandom_range(0, 1) == 1) do_clear();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
